// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus collector with per-unit result FIFOs and round-robin broadcast.
// Optional CDB_BYPASS_EN lets a result from an empty unit skip its FIFO and broadcast one cycle sooner.
module cdb_arbiter #(
  parameter int NUM_UNITS  = 7,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET,
  input  logic [NUM_UNITS-1:0]        unit_valid,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_result,
  output logic [NUM_UNITS-1:0]        unit_ready,
  input  logic                        cdb_stall,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data
);
  localparam int IDX_W = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
  localparam int PTR_W = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  logic [DATA_W-1:0]    mem [NUM_UNITS][FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr [NUM_UNITS];
  logic [PTR_W-1:0]     wr_ptr [NUM_UNITS];
  logic [CNT_W-1:0]     count [NUM_UNITS];
  logic [IDX_W-1:0]     rr_ptr, win;
  logic [NUM_UNITS-1:0] nonempty, byp, cand, push, pop;
  logic                 found, grant;
  logic [DATA_W-1:0]    win_data;
  int                   j;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p == PTR_W'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // ready looks only at the registered count, so a same-cycle pop never frees a slot
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      nonempty[i]   = count[i] != '0;
      unit_ready[i] = !RESET && count[i] < CNT_W'(FIFO_DEPTH);
    end
  end

`ifdef CDB_BYPASS_EN
  assign byp = ~nonempty & unit_valid & unit_ready;
`else
  assign byp = '0;
`endif
  assign cand = nonempty | byp;

  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      j = int'(rr_ptr) + k;
      j = j >= NUM_UNITS ? j - NUM_UNITS : j;
      if (!found && cand[IDX_W'(j)]) begin
        found = 1'b1;
        win   = IDX_W'(j);
      end
    end
  end

  assign grant    = found && !cdb_stall;
  assign win_data = nonempty[win] ? mem[win][rd_ptr[win]] : unit_result[win*DATA_W +: DATA_W];

  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      pop[i]  = grant && win == IDX_W'(i) && nonempty[i];
      push[i] = unit_valid[i] && unit_ready[i] && !(grant && win == IDX_W'(i) && byp[i]);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      rr_ptr    <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      cdb_valid <= grant;
      cdb_tag   <= grant ? TAG_W'(win) + TAG_W'(1) : '0;
      cdb_data  <= grant ? win_data : '0;
      rr_ptr    <= grant ? (win == IDX_W'(NUM_UNITS - 1) ? '0 : win + 1'b1) : rr_ptr;
      for (int i = 0; i < NUM_UNITS; i++) begin
        wr_ptr[i] <= push[i] ? ptr_inc(wr_ptr[i]) : wr_ptr[i];
        rd_ptr[i] <= pop[i] ? ptr_inc(rd_ptr[i]) : rd_ptr[i];
        count[i]  <= push[i] == pop[i] ? count[i] : push[i] ? count[i] + 1'b1 : count[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    for (int i = 0; i < NUM_UNITS; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= unit_result[i*DATA_W +: DATA_W];
  end
endmodule
